// File: rtl/board_pos_tracker.sv
// Board position tracker: holds ring positions for up to MAX_PLAYERS players,
// loads start tiles in setup mode and walks accepted moves one tile per clock.
module board_pos_tracker #(
    parameter int unsigned MAX_PLAYERS  = 4,
    parameter int unsigned NUM_TILES    = 24,
    parameter int unsigned POS_W        = 5,
    parameter int unsigned PID_W        = 2,
    parameter int unsigned STEP_W       = 4,
    parameter int unsigned START_STRIDE = 6,
    parameter logic [2:0]  SETUP_MODE   = 3'b010
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [2:0]                   M,
    input  logic [2:0]                   N,
    input  logic                         mv_valid,
    input  logic [PID_W-1:0]             mv_player,
    input  logic [STEP_W-1:0]            mv_steps,
    output logic                         mv_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         mv_err,
    output logic                         lap,
    output logic [MAX_PLAYERS-1:0]       pass_mask,
    output logic [MAX_PLAYERS*POS_W-1:0] pos_flat
);

    localparam int unsigned CNT_W = $clog2(MAX_PLAYERS + 1);
    localparam logic [POS_W-1:0] POS_OFF  = '1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_TILES - 1);

    typedef enum logic {S_IDLE, S_STEP} state_e;

    state_e                 state_q, state_d;
    logic [POS_W-1:0]       pos_q [MAX_PLAYERS];
    logic [POS_W-1:0]       pos_d [MAX_PLAYERS];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PID_W-1:0]       player_q, player_d;
    logic [STEP_W-1:0]      rem_q, rem_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   lap_q, lap_d;
    logic [MAX_PLAYERS-1:0] pass_q, pass_d;
    logic [POS_W-1:0]       mover_cur, mover_nxt;
    logic                   setup;
    logic                   req_ok;

    assign setup    = (M == SETUP_MODE);
    assign mv_ready = (state_q == S_IDLE) && !setup && (cnt_q != '0);
    assign req_ok   = (cnt_q != '0) && (32'(mv_player) < 32'(cnt_q)) && (mv_steps != '0);

    // Mover's next tile with exact wrap at the end of the ring.
    assign mover_cur = pos_q[player_q];
    assign mover_nxt = (mover_cur == POS_LAST) ? '0 : mover_cur + POS_W'(1);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        lap_d    = 1'b0;

        if (setup) begin
            // Setup overrides everything, including a move in flight.
            if (N == 3'd0)
                cnt_d = CNT_W'(1);
            else if (32'(N) > MAX_PLAYERS)
                cnt_d = CNT_W'(MAX_PLAYERS);
            else
                cnt_d = CNT_W'(N);
            for (int unsigned i = 0; i < MAX_PLAYERS; i++) begin
                pos_d[i] = (CNT_W'(i) < cnt_d) ? POS_W'((i * START_STRIDE) % NUM_TILES) : POS_OFF;
            end
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mv_valid) begin
                        if (req_ok) begin
                            state_d  = S_STEP;
                            player_d = mv_player;
                            rem_d    = mv_steps;
                            pass_d   = '0;
                            busy_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    pos_d[player_q] = mover_nxt;
                    lap_d           = (mover_cur == POS_LAST);
                    rem_d           = rem_q - STEP_W'(1);
                    for (int unsigned j = 0; j < MAX_PLAYERS; j++) begin
                        if ((j != 32'(player_q)) && (CNT_W'(j) < cnt_q) && (pos_q[j] == mover_nxt))
                            pass_d[j] = 1'b1;
                    end
                    if (rem_q == STEP_W'(1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            for (int unsigned i = 0; i < MAX_PLAYERS; i++) pos_q[i] <= POS_OFF;
            cnt_q    <= '0;
            player_q <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            lap_q    <= 1'b0;
            pass_q   <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            player_q <= player_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            lap_q    <= lap_d;
            pass_q   <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mv_err    = err_q;
    assign lap       = lap_q;
    assign pass_mask = pass_q;

    always_comb begin
        pos_flat = '0;
        for (int unsigned i = 0; i < MAX_PLAYERS; i++) pos_flat[i*POS_W +: POS_W] = pos_q[i];
    end

endmodule

// File: tb/tb_board_pos_tracker.sv
// Randomised bench for board_pos_tracker against a ring-arithmetic reference model.
module tb_board_pos_tracker;

    localparam int NP   = 4;
    localparam int NT   = 24;
    localparam int PW   = 5;
    localparam int OFF  = 31;
    localparam int STR  = 6;
    localparam logic [2:0] SETUP = 3'b010;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     M = 3'd0;
    logic [2:0]     N = 3'd0;
    logic           mv_valid = 1'b0;
    logic [1:0]     mv_player = 2'd0;
    logic [3:0]     mv_steps = 4'd0;
    logic           mv_ready, busy, done, mv_err, lap;
    logic [NP-1:0]  pass_mask;
    logic [NP*PW-1:0] pos_flat;

    int tests = 0;
    int fails = 0;
    int exp_pos [NP];
    int cnt = 0;

    board_pos_tracker dut (
        .clk(clk), .rst_n(rst_n), .M(M), .N(N),
        .mv_valid(mv_valid), .mv_player(mv_player), .mv_steps(mv_steps),
        .mv_ready(mv_ready), .busy(busy), .done(done), .mv_err(mv_err),
        .lap(lap), .pass_mask(pass_mask), .pos_flat(pos_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] f = '0;
        for (int i = 0; i < NP; i++) f = f | (32'(exp_pos[i] & OFF) << (i * PW));
        return f;
    endfunction

    function automatic void model_setup(input int n);
        cnt = (n == 0) ? 1 : ((n > NP) ? NP : n);
        for (int i = 0; i < NP; i++) exp_pos[i] = (i < cnt) ? (i * STR) % NT : OFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] play_mode();
        int m = $urandom_range(0, 6);
        if (m >= 2) m++;
        return 3'(m);
    endfunction

    task automatic do_setup(input int n);
        M = SETUP;
        N = 3'(n);
        tick();
        model_setup(n);
        check("setup_pos", 32'(pos_flat), model_flat());
        check("setup_ready", 32'(mv_ready), 32'd0);
        check("setup_busy", 32'(busy), 32'd0);
        M = play_mode();
        #1;
        check("post_setup_ready", 32'(mv_ready), 32'd1);
    endtask

    // Expected trajectory: tile (start+s) mod NT after step s; pass set = active others on any visited tile.
    task automatic do_move(input int p, input int k);
        bit ok;
        int start, np;
        int mask;
        ok = (cnt > 0) && (p < cnt) && (k != 0);
        check("ready_pre", 32'(mv_ready), (cnt > 0) ? 32'd1 : 32'd0);
        mv_valid  = 1'b1;
        mv_player = 2'(p);
        mv_steps  = 4'(k);
        tick();
        mv_valid = 1'b0;
        check("done_cleared", 32'(done), 32'd0);
        if (!ok) begin
            check("err_pulse", 32'(mv_err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_pos", 32'(pos_flat), model_flat());
            tick();
            check("err_drop", 32'(mv_err), 32'd0);
        end else begin
            check("acc_busy", 32'(busy), 32'd1);
            check("acc_err", 32'(mv_err), 32'd0);
            start = exp_pos[p];
            mask  = 0;
            for (int s = 1; s <= k; s++) begin
                tick();
                np = (start + s) % NT;
                exp_pos[p] = np;
                for (int j = 0; j < cnt; j++)
                    if (j != p && exp_pos[j] == np) mask |= (1 << j);
                check("step_pos", 32'(pos_flat), model_flat());
                check("step_lap", 32'(lap), (np == 0) ? 32'd1 : 32'd0);
                check("step_busy", 32'(busy), (s < k) ? 32'd1 : 32'd0);
                check("step_done", 32'(done), (s == k) ? 32'd1 : 32'd0);
            end
            check("pass_mask", 32'(pass_mask), 32'(mask));
            check("ready_done", 32'(mv_ready), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) exp_pos[i] = OFF;
        #12;
        check("rst_pos", 32'(pos_flat), model_flat());
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(mv_ready), 32'd0);
        check("rst_pass", 32'(pass_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        M = 3'd0;

        // With no active players every request is rejected.
        do_move(0, 3);

        do_setup(3);
        do_move(0, 5);
        do_setup(4);
        do_move(3, 8);
        do_setup(4);
        do_move(1, 6);
        do_move(2, 3);
        do_setup(2);
        do_move(3, 4);
        do_move(0, 0);

        // Setup mid-move aborts without a done pulse.
        do_setup(4);
        mv_valid = 1'b1; mv_player = 2'd0; mv_steps = 4'd10;
        tick();
        mv_valid = 1'b0;
        tick(); tick(); tick();
        M = SETUP; N = 3'd4;
        tick();
        model_setup(4);
        check("abort_pos", 32'(pos_flat), model_flat());
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        M = 3'd0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_hold_pos", 32'(pos_flat), model_flat());

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) == 0) do_setup($urandom_range(0, 7));
            else begin
                M = play_mode();
                do_move($urandom_range(0, 3), $urandom_range(0, 15));
            end
        end

        // Asynchronous reset between edges in the middle of a move.
        do_setup(4);
        mv_valid = 1'b1; mv_player = 2'd1; mv_steps = 4'd9;
        tick();
        mv_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NP; i++) exp_pos[i] = OFF;
        cnt = 0;
        check("arst_pos", 32'(pos_flat), model_flat());
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(mv_ready), 32'd0);
        check("arst_pass", 32'(pass_mask), 32'd0);
        check("arst_lap", 32'(lap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        M = 3'd0;
        #1;
        check("arst_ready_after", 32'(mv_ready), 32'd0);
        do_move(2, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/board_pos_tracker.md
Name: board_pos_tracker

Overview:
- Parametrised successor to the per-player tile counters.
- One block holds the board position of up to MAX_PLAYERS players on a ring of NUM_TILES tiles.
- Loads start positions in setup mode and executes multi-tile moves one tile per clock.
- Reports wrap-around (lap) and which opponents the mover passed or landed on; sits between game-control FSM and display/scoring logic.

Parameters:
- MAX_PLAYERS, 4, number of player slots; players indexed 0..MAX_PLAYERS-1.
- NUM_TILES, 24, tiles on the ring; legal positions 0..NUM_TILES-1.
- POS_W, 5, position width; NUM_TILES < 2**POS_W is required so all-ones is free as the OFF sentinel.
- PID_W, 2, player-index width; 2**PID_W >= MAX_PLAYERS.
- STEP_W, 4, move-length width.
- START_STRIDE, 6, tile spacing between consecutive players' start tiles.
- SETUP_MODE, 3'b010, value of M that selects setup.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- M  in  3  game mode; M==SETUP_MODE loads start positions.
- N  in  3  active player count, 1..MAX_PLAYERS; sampled only in setup.
- mv_valid  in  1  move request.
- mv_player  in  PID_W  player to move.
- mv_steps  in  STEP_W  tiles to advance.
- mv_ready  out  1  high when idle and M!=SETUP_MODE; a move is accepted on mv_valid&&mv_ready.
- busy  out  1  high while a move is stepping.
- done  out  1  one-cycle pulse after a move's final step.
- mv_err  out  1  one-cycle pulse on a rejected request.
- lap  out  1  one-cycle pulse on any step that wraps NUM_TILES-1 -> 0.
- pass_mask  out  MAX_PLAYERS  opponents touched during the last move; valid while done is high, held until the next accept.
- pos_flat  out  MAX_PLAYERS*POS_W  positions; player i at bits [i*POS_W +: POS_W].

Behaviour:
- Reset (async, rst_n=0):
  - All positions = OFF (all-ones).
  - State IDLE; busy, done, mv_err, lap = 0; pass_mask = 0; active count = 0.
- Setup, every clock with M==SETUP_MODE:
  - Active count latched = min(N, MAX_PLAYERS); N==0 is treated as 1.
  - Player i < count gets position (i*START_STRIDE) mod NUM_TILES; other players get OFF.
  - Any in-progress move is aborted: state to IDLE, busy=0, no done pulse.
  - mv_ready=0 throughout.
- FSM states IDLE and STEP:
  - IDLE -> STEP on accept with mv_player < count and mv_steps != 0.
  - On that accept: latch player and remaining=mv_steps, clear pass_mask, busy=1.
  - Accept with mv_player >= count or mv_steps==0: stay IDLE, mv_err=1 next cycle, positions unchanged.
  - STEP, each clock:
    - Mover position advances one tile: NUM_TILES-1 wraps to 0 with lap=1 that cycle, else +1.
    - remaining decrements.
    - Any active opponent j whose position equals the mover's new position sets pass_mask[j].
  - STEP -> IDLE on the step where remaining==1; on that same edge done=1 and busy=0.
- Latency: a k-step move accepted at edge 0 updates position at edges 1..k; done is high in the cycle after edge k. mv_ready is high in that done cycle, so back-to-back moves are allowed.
- Mover never sets its own pass_mask bit; OFF players never match.
- Requests while busy are ignored: mv_ready=0, no error.
- Arithmetic: position compare and wrap are exact; no modulo of values >= NUM_TILES is ever stored.
- A move may exceed NUM_TILES; laps repeat and lap pulses once per wrap.

Test Plan:
- Reset then M=SETUP_MODE, N=3 for 1 clk -> pos = {OFF,12,6,0} (players 3..0), mv_ready=0 during setup, 1 after.
- Move player 0, 5 steps -> pos0 = 1,2,3,4,5 on consecutive edges; busy high 5 cycles; done 1 cycle after 5th edge; pass_mask=0; mv_ready high in done cycle.
- Setup N=4 to give player 3 position 18; move player 3, 8 steps -> reaches 23, 0 (lap pulse), ..., ends at 2; pass_mask=0001 (passes player 0 at 0).
- Player 1 at 6, move 6 steps -> lands on 12; pass_mask bit2=1; done then back-to-back move of player 2 accepted in the done cycle.
- Setup N=2, request player 3 -> mv_err pulse, no busy; steps=0 request -> mv_err; assert setup mid-move -> positions reload, busy drops, no done.
- Deassert rst_n mid-move (async, between edges) -> all outputs/positions immediately OFF/0; after release, mv_ready=0 until setup is issued (active count 0 makes any move an mv_err).
